uart_xmit_fifo: RTL and testbench

- Buffered UART transmitter. It is the transmit-direction counterpart to the receive path in the uart top level.
- The host writes bytes into an internal FIFO. A baud-timed serializer drains the FIFO onto the serial line as 8N1 frames, sent LSB first.
- It is a drop-in replacement for the unbuffered transmitter. It adds back-to-back framing, a ready flag and an overflow flag.

---
 rtl/uart_xmit_fifo_if.sv | 36 +++
 rtl/uart_xmit_fifo.sv | 172 +++++++++++++++++
 tb/tb_uart_xmit_fifo.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_xmit_fifo_if.sv
// Host-side bus of the buffered UART transmitter.
// master = host that writes bytes, slave = the transmitter.
interface uart_xmit_fifo_if #(
   parameter int FIFO_AW = 3
);
   logic               xmitH;
   logic [7:0]         xmit_dataH;
   logic               xmit_readyH;
   logic [FIFO_AW:0]   xmit_countH;
   logic               uart_xmitH;
   logic               xmit_busyH;
   logic               xmit_doneH;
   logic               xmit_overflowH;

   modport master (
      output xmitH,
      output xmit_dataH,
      input  xmit_readyH,
      input  xmit_countH,
      input  uart_xmitH,
      input  xmit_busyH,
      input  xmit_doneH,
      input  xmit_overflowH
   );

   modport slave (
      input  xmitH,
      input  xmit_dataH,
      output xmit_readyH,
      output xmit_countH,
      output uart_xmitH,
      output xmit_busyH,
      output xmit_doneH,
      output xmit_overflowH
   );
endinterface

// File: rtl/uart_xmit_fifo.sv
// Buffered UART transmitter: byte FIFO drained as 8N1 frames, LSB first.
// Define UART_XMIT_PARITY_EN for 8E1 framing (even parity bit after data).
module uart_xmit_fifo #(
   parameter int BAUD_DIV = 434,
   parameter int FIFO_AW  = 3
) (
   input  logic            sys_clk,
   input  logic            sys_rst,
   uart_xmit_fifo_if.slave bus
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int BW    = $clog2(BAUD_DIV);

   localparam logic [BW-1:0]      BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0]      BAUD_ONE  = BW'(1);
   localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

`ifdef UART_XMIT_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_START, S_DATA, S_STOP
   } state_t;
`endif

   logic [7:0]         r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wr_ptr;
   logic [FIFO_AW-1:0] r_rd_ptr;
   logic [FIFO_AW:0]   r_count;
   logic               r_ovf;

   state_t             r_state;
   logic [BW-1:0]      r_baud;
   logic [2:0]         r_idx;
   logic [7:0]         r_shift;
   logic               r_line;
   logic               r_done;
`ifdef UART_XMIT_PARITY_EN
   logic               r_par;
`endif

   logic w_full;
   logic w_empty;
   logic w_bit_end;
   logic w_pop;
   logic w_push;

   assign w_full    = (r_count == CNT_FULL);
   assign w_empty   = (r_count == '0);
   assign w_bit_end = (r_baud == BAUD_LAST);

   // Pop on idle, or at the end of a stop bit to chain frames without a gap.
   assign w_pop  = !w_empty &&
                   ((r_state == S_IDLE) ||
                    ((r_state == S_STOP) && w_bit_end));
   assign w_push = bus.xmitH && (!w_full || w_pop);

   always_ff @(posedge sys_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= bus.xmit_dataH;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
         if (bus.xmitH && !w_push) r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_line  <= 1'b1;
         r_done  <= 1'b0;
`ifdef UART_XMIT_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         if (r_state != S_IDLE) begin
            r_baud <= w_bit_end ? '0 : r_baud + BAUD_ONE;
         end
         if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
`ifdef UART_XMIT_PARITY_EN
            r_par   <= ^r_mem[r_rd_ptr];
`endif
         end
         unique case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_state <= S_START;
                  r_line  <= 1'b0;
                  r_baud  <= '0;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_state <= S_DATA;
                  r_idx   <= '0;
                  r_line  <= r_shift[0];
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  if (r_idx == 3'd7) begin
`ifdef UART_XMIT_PARITY_EN
                     r_state <= S_PARITY;
                     r_line  <= r_par;
`else
                     r_state <= S_STOP;
                     r_line  <= 1'b1;
`endif
                  end else begin
                     r_idx  <= r_idx + 3'd1;
                     r_line <= r_shift[r_idx + 3'd1];
                  end
               end
            end
`ifdef UART_XMIT_PARITY_EN
            S_PARITY: begin
               if (w_bit_end) begin
                  r_state <= S_STOP;
                  r_line  <= 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (w_bit_end) begin
                  r_done <= 1'b1;
                  if (w_pop) begin
                     r_state <= S_START;
                     r_line  <= 1'b0;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_line  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.uart_xmitH     = r_line;
   assign bus.xmit_busyH     = (r_state != S_IDLE);
   assign bus.xmit_doneH     = r_done;
   assign bus.xmit_overflowH = r_ovf;
   assign bus.xmit_readyH    = !w_full;
   assign bus.xmit_countH    = r_count;

endmodule

// File: tb/tb_uart_xmit_fifo.sv
// Bench for uart_xmit_fifo: frame-vector table, corner sequences and
// random traffic checked every cycle against a queue-based frame model.
module tb_uart_xmit_fifo;

   localparam int BD    = 4;
   localparam int AW    = 2;
   localparam int DEPTH = 4;
`ifdef UART_XMIT_PARITY_EN
   localparam int NB    = 11;
`else
   localparam int NB    = 10;
`endif
   localparam int FRAME = NB * BD;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   always #5 sys_clk = ~sys_clk;

   uart_xmit_fifo_if #(.FIFO_AW(AW)) bus ();

   uart_xmit_fifo #(
      .BAUD_DIV(BD),
      .FIFO_AW (AW)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .bus    (bus)
   );

   typedef struct {
      logic [7:0]    data;
      logic [NB-1:0] bits;
   } vec_t;

   vec_t tv [5];

   logic [7:0] mq [$];
   int         rem;
   logic [7:0] cur;
   bit         movf;
   bit         mdone;
   int         n_pass;
   int         n_total;
   int         cyc;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at cycle %0d",
                    name, act, exp, cyc);
   endtask

   // Line level from position inside the current frame.
   function automatic logic exp_line();
      int b;
      if (rem == 0) return 1'b1;
      b = (FRAME - rem) / BD;
      if (b == 0) return 1'b0;
      if (b <= 8) return cur[b-1];
      if (b == 9 && NB == 11) return ^cur;
      return 1'b1;
   endfunction

   function automatic logic [7:0] exp_vec();
      return {exp_line(), mq.size() < DEPTH, rem > 0,
              mdone, movf, 3'(mq.size())};
   endfunction

   function automatic logic [7:0] act_vec();
      return {bus.uart_xmitH, bus.xmit_readyH, bus.xmit_busyH,
              bus.xmit_doneH, bus.xmit_overflowH, bus.xmit_countH};
   endfunction

   task automatic tick(input bit wr, input logic [7:0] d, input bit rst);
      bit pop;
      bit acc;
      sys_rst         = rst;
      bus.xmitH       = wr;
      bus.xmit_dataH  = d;
      @(posedge sys_clk);
      if (rst) begin
         mq.delete();
         rem   = 0;
         movf  = 0;
         mdone = 0;
      end else begin
         pop   = (mq.size() > 0) && (rem <= 1);
         mdone = (rem == 1);
         acc   = wr && ((mq.size() < DEPTH) || pop);
         if (wr && !acc) movf = 1;
         if (pop) begin
            cur = mq.pop_front();
            rem = FRAME;
         end else if (rem > 0) begin
            rem--;
         end
         if (acc) mq.push_back(d);
      end
      cyc++;
      #1;
      chk("cycle", 32'(act_vec()), 32'(exp_vec()));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(rem == 0 && mq.size() == 0) && n < 400) begin
         tick(0, 8'h00, 0);
         n++;
      end
      chk("idle_wait", {bus.xmit_busyH, bus.xmit_countH}, 0);
   endtask

   task automatic run_vec(input int i);
      logic [NB-1:0] got;
      int            done_at;
      logic          busy_at;
      got     = '0;
      done_at = -1;
      busy_at = 1'b1;
      wait_idle();
      tick(1, tv[i].data, 0);
      for (int k = 1; k <= FRAME + 1; k++) begin
         tick(0, 8'h00, 0);
         if ((k - 1) % BD == 1) got[(k - 1) / BD] = bus.uart_xmitH;
         if (bus.xmit_doneH && done_at < 0) begin
            done_at = k;
            busy_at = bus.xmit_busyH;
         end
      end
      chk("frame_bits", 32'(got), 32'(tv[i].bits));
      chk("done_edge", done_at, FRAME + 1);
      chk("busy_at_done", busy_at, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   d_at [$];
      bit   seen_done;
      int   ndone;
      logic wr;

`ifdef UART_XMIT_PARITY_EN
      tv[0] = '{8'h07, 11'b11000001110};
      tv[1] = '{8'h03, 11'b10000000110};
      tv[2] = '{8'hA5, 11'b10101001010};
      tv[3] = '{8'h00, 11'b10000000000};
      tv[4] = '{8'h55, 11'b10010101010};
`else
      tv[0] = '{8'hA5, 10'b1101001010};
      tv[1] = '{8'h00, 10'b1000000000};
      tv[2] = '{8'hFF, 10'b1111111110};
      tv[3] = '{8'h3C, 10'b1001111000};
      tv[4] = '{8'h55, 10'b1010101010};
`endif
      n_pass  = 0;
      n_total = 0;
      cyc     = 0;
      bus.xmitH      = 1'b0;
      bus.xmit_dataH = 8'h00;

      tick(0, 8'h00, 1);
      tick(0, 8'h00, 1);
      seen_done = 0;
      for (int k = 0; k < 20; k++) begin
         tick(0, 8'h00, 0);
         if (bus.xmit_doneH) seen_done = 1;
      end
      chk("rst_line", bus.uart_xmitH, 1);
      chk("rst_ready", bus.xmit_readyH, 1);
      chk("rst_count", bus.xmit_countH, 0);
      chk("rst_no_done", seen_done, 0);

      for (int i = 0; i < 4; i++) run_vec(i);

      // three bytes back to back
      wait_idle();
      tick(1, 8'h00, 0);
      tick(1, 8'hFF, 0);
      tick(1, 8'h3C, 0);
      chk("b2b_count", bus.xmit_countH, 2);
      for (int k = 1; k <= 3 * FRAME + 10; k++) begin
         tick(0, 8'h00, 0);
         if (bus.xmit_doneH) d_at.push_back(k);
      end
      chk("b2b_ndone", d_at.size(), 3);
      if (d_at.size() == 3) begin
         chk("b2b_gap1", d_at[1] - d_at[0], FRAME);
         chk("b2b_gap2", d_at[2] - d_at[1], FRAME);
      end

      // six writes into a depth-4 FIFO
      wait_idle();
      for (int k = 0; k < 6; k++) begin
         tick(1, 8'(8'h10 + k), 0);
         if (k == 4) begin
            chk("ovf_ready", bus.xmit_readyH, 0);
            chk("ovf_count", bus.xmit_countH, 4);
         end
      end
      chk("ovf_flag", bus.xmit_overflowH, 1);
      ndone = 0;
      for (int k = 0; k < 5 * FRAME + 20; k++) begin
         tick(0, 8'h00, 0);
         if (bus.xmit_doneH) ndone++;
      end
      chk("ovf_frames", ndone, 5);
      chk("ovf_sticky", bus.xmit_overflowH, 1);

      // reset in the middle of a data bit
      wait_idle();
      tick(1, 8'h81, 0);
      for (int k = 0; k < 15; k++) tick(0, 8'h00, 0);
      tick(0, 8'h00, 1);
      chk("mid_rst_line", bus.uart_xmitH, 1);
      chk("mid_rst_count", bus.xmit_countH, 0);
      chk("mid_rst_busy", bus.xmit_busyH, 0);
      chk("mid_rst_ovf", bus.xmit_overflowH, 0);
      run_vec(4);

      for (int k = 0; k < 1500; k++) begin
         wr = ($urandom_range(0, 99) < 9);
         tick(wr, 8'($urandom), ($urandom_range(0, 599) == 0));
      end
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
